// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank divider channels.
// CLKGEN_PHASE_EN adds a phase field to the channel configuration.
package clk_div_pkg;

  // Config fields are carried at a fixed width; DIV_W of the bank must not exceed it.
  localparam int CFG_W      = 32;
  localparam int LOCK_CNT_W = 8;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
`ifdef CLKGEN_PHASE_EN
    logic [CFG_W-1:0] phase;
`endif
  } chan_cfg_t;

  function automatic logic [CFG_W-1:0] clamp_high(input logic [CFG_W-1:0] div,
                                                  input logic [CFG_W-1:0] high);
    if ((div >= CFG_W'(2)) && ((high == '0) || (high >= div))) return div >> 1;
    return high;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/pending config, lock counter, output registers.
// With CLKGEN_PHASE_EN the counter restarts at the configured phase on apply.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int RESET_DIV    = 2,
  parameter int RESET_HIGH   = 1,
  parameter int LOCK_PERIODS = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      cfg_we,
  input  chan_cfg_t cfg_in,
  output logic      pending,
  output logic      enabled,
  output logic      clk_out,
  output logic      ce,
  output logic      locked
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(LOCK_PERIODS);

  logic [CFG_W-1:0]      div_q, div_d, high_q, high_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d, start_cnt;
  logic [LOCK_CNT_W-1:0] lock_q, lock_d;
  logic                  pend_q, pend_d;
  logic                  clk_out_q, ce_q, locked_q;
  logic                  wrap, apply_now;
  chan_cfg_t             shadow_q;

  assign enabled   = (div_q >= CFG_W'(2));
  assign wrap      = enabled && (CFG_W'(cnt_q) == (div_q - CFG_W'(1)));
  assign apply_now = pend_q && (!enabled || wrap);

`ifdef CLKGEN_PHASE_EN
  always_comb begin
    start_cnt = '0;
    if (shadow_q.div >= CFG_W'(2))
      start_cnt = DIV_W'((shadow_q.phase < shadow_q.div) ? shadow_q.phase
                                                         : (shadow_q.div - CFG_W'(1)));
  end
`else
  assign start_cnt = '0;
`endif

  always_comb begin
    div_d  = div_q;
    high_d = high_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    pend_d = pend_q;
    if (enabled) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      if (wrap && (lock_q != LOCK_MAX)) lock_d = lock_q + LOCK_CNT_W'(1);
    end else begin
      cnt_d  = '0;
      lock_d = '0;
    end
    // New config takes effect only at a period boundary (or at once when idle).
    if (apply_now) begin
      div_d  = shadow_q.div;
      high_d = shadow_q.high;
      cnt_d  = start_cnt;
      lock_d = '0;
      pend_d = 1'b0;
    end
    if (cfg_we) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= CFG_W'(RESET_DIV);
      high_q    <= CFG_W'(RESET_HIGH);
      cnt_q     <= '0;
      lock_q    <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      ce_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      high_q    <= high_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      pend_q    <= pend_d;
      clk_out_q <= enabled && (CFG_W'(cnt_q) < high_q);
      ce_q      <= enabled && (cnt_q == '0);
      locked_q  <= enabled && (lock_q == LOCK_MAX);
    end
  end

  // Shadow is pure data, qualified by pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      shadow_q      <= cfg_in;
      shadow_q.high <= clamp_high(cfg_in.div, cfg_in.high);
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_out_q;
  assign ce      = ce_q;
  assign locked  = locked_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with per-channel lock indication.
// Optional CLKGEN_PHASE_EN adds cfg_phase for phase-offset channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DIV_W        = 16,
  parameter int RESET_DIV    = 2,
  parameter int RESET_HIGH   = 1,
  parameter int LOCK_PERIODS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_channel,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W-1:0]          cfg_high,
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]          cfg_phase,
`endif
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       locked,
  output logic                      all_locked
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending, enabled, we;
  chan_cfg_t           cfg_req;
  logic                accept;

  always_comb begin
    cfg_req      = '0;
    cfg_req.div  = CFG_W'(cfg_div);
    cfg_req.high = CFG_W'(cfg_high);
`ifdef CLKGEN_PHASE_EN
    cfg_req.phase = CFG_W'(cfg_phase);
`endif
  end

  // Requests to a non-existent channel are accepted and dropped so a master never stalls.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (cfg_channel == CH_W'(i)) cfg_ready = !pending[i];
  end

  assign accept = cfg_valid && cfg_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign we[g] = accept && (cfg_channel == CH_W'(g));
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .RESET_DIV   (RESET_DIV),
      .RESET_HIGH  (RESET_HIGH),
      .LOCK_PERIODS(LOCK_PERIODS)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .cfg_we (we[g]),
      .cfg_in (cfg_req),
      .pending(pending[g]),
      .enabled(enabled[g]),
      .clk_out(clk_out[g]),
      .ce     (ce[g]),
      .locked (locked[g])
    );
  end

  assign all_locked = (|enabled) && (&(locked | ~enabled));

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized scoreboard bench for clk_div_bank against an arithmetic reference model.
// Build with CLKGEN_PHASE_EN defined to exercise the phase port as well.
module tb_clk_div_bank;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int LP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_channel;
  logic [DW-1:0] cfg_div, cfg_high;
`ifdef CLKGEN_PHASE_EN
  logic [DW-1:0] cfg_phase;
`endif
  logic [CH-1:0] clk_out, ce, locked;
  logic          all_locked;

  int ncmp = 0;
  int nerr = 0;

  clk_div_bank #(.CHANNELS(CH), .DIV_W(DW), .RESET_DIV(2), .RESET_HIGH(1), .LOCK_PERIODS(LP)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_channel(cfg_channel),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase  (cfg_phase),
`endif
    .clk_out    (clk_out),
    .ce         (ce),
    .locked     (locked),
    .all_locked (all_locked)
  );

  always #5 clk = ~clk;

  // Reference model: each channel's counter value is derived from the edge at which its
  // config was applied (mA) and its start offset (mS); lock = completed periods since then.
  int mD[CH], mH[CH], mA[CH], mS[CH], shD[CH], shH[CH], shP[CH];
  bit mPend[CH];
  int tcur;

  typedef struct packed {
    logic [CH-1:0] co;
    logic [CH-1:0] ce;
    logic [CH-1:0] lk;
    logic [CH-1:0] pd;
    logic          al;
  } exp_t;
  exp_t q[$];

  function automatic int cnt_at(int c, int t);
    if (mD[c] < 2) return 0;
    return (mS[c] + t - mA[c]) % mD[c];
  endfunction

  function automatic int lock_at(int c, int t);
    int n;
    if (mD[c] < 2) return 0;
    n = (mS[c] + t - mA[c]) / mD[c];
    return (n > LP) ? LP : n;
  endfunction

  function automatic int ref_clamp(int d, int h);
    if (d >= 2 && (h == 0 || h >= d)) return d / 2;
    return h;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mD[c] = 2; mH[c] = 1; mA[c] = 0; mS[c] = 0; mPend[c] = 1'b0;
    end
    tcur = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   cn, ph;
    bit   en, acc, any_en, all_lk;
    e = '0;
    if (reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        en = (mD[c] >= 2);
        cn = cnt_at(c, tcur);
        e.co[c] = en && (cn < mH[c]);
        e.ce[c] = en && (cn == 0);
        e.lk[c] = en && (lock_at(c, tcur) == LP);
        acc = cfg_valid && (int'(cfg_channel) == c) && !mPend[c];
        if (mPend[c] && (!en || cn == mD[c] - 1)) begin
          mD[c] = shD[c];
          mH[c] = shH[c];
          mA[c] = tcur + 1;
          mS[c] = (shD[c] >= 2) ? ((shP[c] < shD[c]) ? shP[c] : shD[c] - 1) : 0;
          mPend[c] = 1'b0;
        end
        if (acc) begin
          ph = 0;
`ifdef CLKGEN_PHASE_EN
          ph = int'(cfg_phase);
`endif
          shD[c] = int'(cfg_div);
          shH[c] = ref_clamp(int'(cfg_div), int'(cfg_high));
          shP[c] = ph;
          mPend[c] = 1'b1;
        end
        e.pd[c] = mPend[c];
      end
      any_en = 1'b0;
      all_lk = 1'b1;
      for (int c = 0; c < CH; c++) begin
        if (mD[c] >= 2) begin
          any_en = 1'b1;
          if (!e.lk[c]) all_lk = 1'b0;
        end
      end
      e.al = any_en && all_lk;
      tcur++;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (reset) e = '0;
      exp_rdy = !e.pd[cfg_channel];
      ncmp++;
      if ({clk_out, ce, locked, all_locked, cfg_ready} !== {e.co, e.ce, e.lk, e.al, exp_rdy}) begin
        nerr++;
        $display("FAIL outputs t=%0t clk_out=%b/%b ce=%b/%b locked=%b/%b all_locked=%b/%b ready=%b/%b (actual/required)",
                 $time, clk_out, e.co, ce, e.ce, locked, e.lk, all_locked, e.al, cfg_ready, exp_rdy);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int d, input int h, input int ph, output int waited);
    logic r;
    cfg_channel = 2'(ch);
    cfg_div     = DW'(d);
    cfg_high    = DW'(h);
`ifdef CLKGEN_PHASE_EN
    cfg_phase   = DW'(ph);
`else
    if (ph < 0) cfg_high = DW'(h);
`endif
    cfg_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      r = cfg_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 300) begin
        ncmp++;
        nerr++;
        $display("FAIL handshake_timeout ch=%0d waited=%0d required<=300", ch, waited);
        break;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    ncmp++;
    if ({clk_out, ce, locked, all_locked, cfg_ready} !== {{(3*CH+1){1'b0}}, 1'b1}) begin
      nerr++;
      $display("FAIL async_reset clk_out=%b ce=%b locked=%b all_locked=%b ready=%b required 0/0/0/0/1",
               clk_out, ce, locked, all_locked, cfg_ready);
    end
    idle(2);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, d;
    reset = 1'b1; cfg_valid = 1'b0; cfg_channel = '0; cfg_div = '0; cfg_high = '0;
`ifdef CLKGEN_PHASE_EN
    cfg_phase = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    idle(20);

    send(1, 5, 2, 0, w);   idle(40);
    send(2, 4, 0, 0, w);
    send(3, 4, 7, 0, w);
    send(0, 1, 3, 0, w);   idle(40);

    send(1, 6, 3, 0, w);
    send(2, 3, 1, 0, w);
    ncmp++;
    if (w != 0) begin
      nerr++;
      $display("FAIL other_channel_accept waited=%0d required=0", w);
    end
    send(1, 3, 1, 0, w);   idle(30);

    send(1, 9, 4, 0, w);
    do_reset();
    idle(25);

`ifdef CLKGEN_PHASE_EN
    send(0, 8, 4, 0, w);
    send(1, 8, 4, 2, w);   idle(60);
`endif

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       d = $urandom_range(0, 1);
        1:       d = 40;
        default: d = $urandom_range(2, 12);
      endcase
      send($urandom_range(0, CH - 1), d, $urandom_range(0, 15), $urandom_range(0, 15), w);
      idle($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
